// File: rtl/layer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the layer sequencer and the engines it controls.
//   seq_state_t : sequencer FSM states
//   STAGE_*     : encoding of the externally visible stage field
//   ELEM_W      : feature-map element width, shared with relu and max_pool2d
//   stage_code  : maps an FSM state to its visible stage code
// ---------------------------------------------------------------------------
package seq_pkg;

  localparam int ELEM_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RELU,
    POOL,
    FINISH,
    ERR
  } seq_state_t;

  localparam logic [1:0] STAGE_IDLE   = 2'd0;  // also reported while in ERR
  localparam logic [1:0] STAGE_RELU   = 2'd1;
  localparam logic [1:0] STAGE_POOL   = 2'd2;
  localparam logic [1:0] STAGE_FINISH = 2'd3;

  function automatic logic [1:0] stage_code(input seq_state_t s);
    case (s)
      RELU:    return STAGE_RELU;
      POOL:    return STAGE_POOL;
      FINISH:  return STAGE_FINISH;
      default: return STAGE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// layer_sequencer_if
// Bundles the host control, engine handshake and result signals of the
// layer sequencer.
//   master : host/engine side (drives start, abort, engine done levels and
//            the pooled map; observes holds, status and the result)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface layer_sequencer_if
  import seq_pkg::*;
#(
  parameter int pooled_width = 3,
  parameter int CNT_W        = 16
);

  localparam int MAP_W = pooled_width * pooled_width * ELEM_W;

  logic                    start;
  logic                    abort;
  logic                    relu_reset;
  logic                    relu_done;
  logic                    max_pool_reset;
  logic                    max_pool_done;
  logic signed [MAP_W-1:0] pooled_map;
  logic signed [MAP_W-1:0] result_map;
  logic                    busy;
  logic                    done;
  logic                    error;
  logic [1:0]              stage;
  logic [CNT_W-1:0]        cycle_count;

  modport master (
    output start, abort, relu_done, max_pool_done, pooled_map,
    input  relu_reset, max_pool_reset, result_map, busy, done, error, stage,
           cycle_count
  );

  modport slave (
    input  start, abort, relu_done, max_pool_done, pooled_map,
    output relu_reset, max_pool_reset, result_map, busy, done, error, stage,
           cycle_count
  );

endinterface

// File: rtl/layer_sequencer_stage_timer.sv
// ---------------------------------------------------------------------------
// stage_timer
// Up-counter with synchronous clear (clear wins over enable) and a
// terminal-count flag decoded from the registered count.
//   clk, reset : clock and asynchronous active-high reset
//   clear      : reload the count with zero
//   enable     : advance the count by one
//   terminal   : count equals TERMINAL
// ---------------------------------------------------------------------------
module stage_timer #(
  parameter int               WIDTH    = 10,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign terminal = (count_reg == TERMINAL);

endmodule

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
// Runs one inference pass per start: relu, then max_pool2d. Each engine is
// released from its hold reset for its stage, its done level is accepted
// only after one settle cycle, and a per-stage timer raises an error when a
// stage overruns. The pooled map is captured on pool completion.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : layer_sequencer_if.slave
//                (start/abort in, engine holds out, engine dones in,
//                 pooled_map in, result_map/busy/done/error/stage/
//                 cycle_count out)
// ---------------------------------------------------------------------------
module layer_sequencer
  import seq_pkg::*;
#(
  parameter int image_width    = 5,
  parameter int pooled_width   = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  layer_sequencer_if.slave bus
);

  localparam int WORDS   = pooled_width * pooled_width;
  localparam int MAP_W   = WORDS * ELEM_W;
  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  // A pooled map can never be wider than the map it was pooled from.
  if (pooled_width < 1 || pooled_width > image_width) begin : g_bad_geometry
    $error("layer_sequencer: pooled_width must lie in 1..image_width");
  end

  seq_state_t       state_reg, state_next;
  logic             settle_reg;
  logic [CNT_W-1:0] count_reg;
  logic [ELEM_W-1:0] result_word_reg [WORDS];
  logic [MAP_W-1:0] result_flat;

  logic start_accept;
  logic capture;
  logic timer_clear;
  logic timer_enable;
  logic timer_last;
  logic relu_accept;
  logic pool_accept;

  // The engine has just left reset in the first cycle of its stage, so its
  // done level is only trusted once settle_reg is set.
  assign relu_accept = bus.relu_done && settle_reg;
  assign pool_accept = bus.max_pool_done && settle_reg;

  // Next state. Priority within a running stage: abort, done, timeout.
  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    capture      = 1'b0;
    case (state_reg)
      IDLE, FINISH, ERR: begin
        if (bus.abort) begin
          // ERR is left only by a new pass; abort parks FINISH in IDLE.
          if (state_reg == FINISH) state_next = IDLE;
        end else if (bus.start) begin
          state_next   = RELU;
          start_accept = 1'b1;
        end
      end
      RELU: begin
        if (bus.abort)        state_next = IDLE;
        else if (relu_accept) state_next = POOL;
        else if (timer_last)  state_next = ERR;
      end
      POOL: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (pool_accept) begin
          state_next = FINISH;
          capture    = 1'b1;
        end else if (timer_last) begin
          state_next = ERR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      settle_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= (state_next == state_reg);
      if (start_accept) begin
        count_reg <= '0;
      end else if ((state_reg == RELU || state_reg == POOL) &&
                   count_reg != CNT_MAX) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // Result capture, one register per pooled element.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_result_word
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        result_word_reg[gi] <= '0;
      end else if (capture) begin
        result_word_reg[gi] <= bus.pooled_map[gi*ELEM_W +: ELEM_W];
      end
    end
  end

  always_comb begin
    result_flat = '0;
    for (int i = 0; i < WORDS; i++) begin
      result_flat[i*ELEM_W +: ELEM_W] = result_word_reg[i];
    end
  end

  // Stage timer restarts on every state change and only runs in a stage.
  assign timer_clear  = (state_next != state_reg);
  assign timer_enable = (state_reg == RELU) || (state_reg == POOL);

  stage_timer #(
    .WIDTH    (TIMER_W),
    .TERMINAL (TIMER_LAST)
  ) u_stage_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .terminal (timer_last)
  );

  // Outputs decoded from the state register only. relu stays released
  // through POOL and FINISH so its output map stays stable for pooling.
  always_comb begin
    bus.relu_reset     = 1'b1;
    bus.max_pool_reset = 1'b1;
    bus.busy           = 1'b0;
    bus.done           = 1'b0;
    bus.error          = 1'b0;
    case (state_reg)
      RELU: begin
        bus.relu_reset = 1'b0;
        bus.busy       = 1'b1;
      end
      POOL: begin
        bus.relu_reset     = 1'b0;
        bus.max_pool_reset = 1'b0;
        bus.busy           = 1'b1;
      end
      FINISH: begin
        bus.relu_reset     = 1'b0;
        bus.max_pool_reset = 1'b0;
        bus.done           = 1'b1;
      end
      ERR:     bus.error = 1'b1;
      default: ;
    endcase
  end

  assign bus.stage       = stage_code(state_reg);
  assign bus.cycle_count = count_reg;
  assign bus.result_map  = result_flat;

endmodule
